// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and helpers for the BTB branch predictor.
//   bp_ctr_e    : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   bp_ctr_next : one saturating step toward taken or not-taken
//   BP_PC_STEP  : sequential fetch increment
package bp_pkg;

   localparam logic [31:0] BP_PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } bp_ctr_e;

   function automatic bp_ctr_e bp_ctr_next(bp_ctr_e cur, logic taken);
      bp_ctr_e nxt;
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = bp_ctr_e'(cur + 2'd1);
      end else begin
         if (cur != SNT) nxt = bp_ctr_e'(cur - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Pipeline <-> predictor signal bundle.
//   master : pipeline side (drives IF PC and EX resolve info, receives prediction/redirect)
//   slave  : predictor side
// Optional BP_PERF_CNT_EN adds o_ctrl_cnt / o_mispred_cnt.
interface branch_predictor_btb_if;
   logic [31:0] i_pc_if;
   logic        o_pred_taken_if;
   logic [31:0] o_pred_pc_if;
   logic        i_valid_ex;
   logic        i_ctrl_ex;
   logic        i_jump_ex;
   logic [31:0] i_pc_ex;
   logic        i_taken_ex;
   logic [31:0] i_target_ex;
   logic        i_pred_taken_ex;
   logic [31:0] i_pred_pc_ex;
   logic        o_mispredict;
   logic [31:0] o_redirect_pc;
`ifdef BP_PERF_CNT_EN
   logic [31:0] o_ctrl_cnt;
   logic [31:0] o_mispred_cnt;
`endif

   modport master (
      output i_pc_if, i_valid_ex, i_ctrl_ex, i_jump_ex, i_pc_ex, i_taken_ex,
             i_target_ex, i_pred_taken_ex, i_pred_pc_ex,
`ifdef BP_PERF_CNT_EN
      input  o_ctrl_cnt, o_mispred_cnt,
`endif
      input  o_pred_taken_if, o_pred_pc_if, o_mispredict, o_redirect_pc
   );

   modport slave (
      input  i_pc_if, i_valid_ex, i_ctrl_ex, i_jump_ex, i_pc_ex, i_taken_ex,
             i_target_ex, i_pred_taken_ex, i_pred_pc_ex,
`ifdef BP_PERF_CNT_EN
      output o_ctrl_cnt, o_mispred_cnt,
`endif
      output o_pred_taken_if, o_pred_pc_if, o_mispredict, o_redirect_pc
   );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// One 2-bit saturating direction counter for a BTB entry.
//   clk, rst_n : clock, async active-low reset (resets to WNT)
//   update     : train an existing entry with outcome 'taken'
//   alloc      : entry is being (re)allocated; loads WT, or ST with force_st
//   force_st   : jump training, counter goes straight to ST
//   ctr        : current counter state
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    update,
   input  logic    alloc,
   input  logic    taken,
   input  logic    force_st,
   output bp_ctr_e ctr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr <= WNT;
      end else if (force_st && (update || alloc)) begin
         ctr <= ST;
      end else if (alloc) begin
         ctr <= WT;
      end else if (update) begin
         ctr <= bp_ctr_next(ctr, taken);
      end
   end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters for a 5-stage RV32I pipeline.
// IF: 0-cycle lookup supplying predicted next PC.
// EX: 0-cycle mispredict/redirect generation, registered table training.
//   i_clk   : system clock
//   i_reset : async active-low reset, clears the whole table
//   bus     : branch_predictor_btb_if.slave (lookup, resolve, redirect)
// Optional macro BP_PERF_CNT_EN adds control-instruction and mispredict counters.
module branch_predictor_btb
   import bp_pkg::*;
#(
   parameter int BTB_ENTRIES = 32
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   branch_predictor_btb_if.slave  bus
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [BTB_ENTRIES-1:0] valid;
   logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
   logic [31:0]            tgt_mem [BTB_ENTRIES];
   bp_ctr_e                ctr     [BTB_ENTRIES];

   logic [IDX_W-1:0] idx_if, idx_ex;
   logic [TAG_W-1:0] tag_if, tag_ex;
   logic             hit_if, hit_ex, pred_taken;
   bp_ctr_e          ctr_if;
   logic [31:0]      actual_npc;
   logic             mispredict;
   logic             ctrl_hit, alloc, inval;

   assign idx_if = bus.i_pc_if[IDX_W+1:2];
   assign tag_if = bus.i_pc_if[31:IDX_W+2];
   assign idx_ex = bus.i_pc_ex[IDX_W+1:2];
   assign tag_ex = bus.i_pc_ex[31:IDX_W+2];

   // Lookup reads the registered table, so a same-cycle EX write is seen next cycle.
   assign hit_if     = valid[idx_if] && (tag_mem[idx_if] == tag_if);
   assign ctr_if     = ctr[idx_if];
   assign pred_taken = hit_if && ((ctr_if == WT) || (ctr_if == ST));

   assign bus.o_pred_taken_if = pred_taken;
   assign bus.o_pred_pc_if    = pred_taken ? tgt_mem[idx_if] : bus.i_pc_if + BP_PC_STEP;

   assign actual_npc        = bus.i_taken_ex ? bus.i_target_ex : bus.i_pc_ex + BP_PC_STEP;
   assign mispredict        = bus.i_valid_ex && (bus.i_pred_pc_ex != actual_npc);
   assign bus.o_mispredict  = mispredict;
   assign bus.o_redirect_pc = actual_npc;

   assign hit_ex   = valid[idx_ex] && (tag_mem[idx_ex] == tag_ex);
   assign ctrl_hit = bus.i_valid_ex && bus.i_ctrl_ex && hit_ex;
   assign alloc    = bus.i_valid_ex && bus.i_ctrl_ex && !hit_ex && bus.i_taken_ex;
   // A non-control instruction that was predicted taken means its PC aliased a
   // control entry; drop the entry so it stops redirecting this fetch.
   assign inval    = bus.i_valid_ex && !bus.i_ctrl_ex && bus.i_pred_taken_ex;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            tag_mem[i] <= '0;
            tgt_mem[i] <= '0;
         end
      end else if (alloc) begin
         valid[idx_ex]   <= 1'b1;
         tag_mem[idx_ex] <= tag_ex;
         tgt_mem[idx_ex] <= bus.i_target_ex;
      end else if (ctrl_hit && bus.i_taken_ex) begin
         tgt_mem[idx_ex] <= bus.i_target_ex;
      end else if (inval) begin
         valid[idx_ex] <= 1'b0;
      end
   end

   for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_ctr
      logic sel;
      assign sel = (idx_ex == IDX_W'(g));
      bp_sat_counter u_ctr (
         .clk      (i_clk),
         .rst_n    (i_reset),
         .update   (sel && ctrl_hit),
         .alloc    (sel && alloc),
         .taken    (bus.i_taken_ex),
         .force_st (bus.i_jump_ex),
         .ctr      (ctr[g])
      );
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] ctrl_cnt, mispred_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ctrl_cnt    <= '0;
         mispred_cnt <= '0;
      end else begin
         if (bus.i_valid_ex && bus.i_ctrl_ex) ctrl_cnt <= ctrl_cnt + 32'd1;
         if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
      end
   end

   assign bus.o_ctrl_cnt    = ctrl_cnt;
   assign bus.o_mispred_cnt = mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb (BTB_ENTRIES=32).
module tb_branch_predictor_btb;

   logic i_clk;
   logic i_reset;
   int   checks;
   int   errors;

   branch_predictor_btb_if bus ();

   branch_predictor_btb #(.BTB_ENTRIES(32)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_ex(input logic v, input logic c, input logic j, input logic [31:0] pc,
                         input logic t, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ppc);
      bus.i_valid_ex      = v;
      bus.i_ctrl_ex       = c;
      bus.i_jump_ex       = j;
      bus.i_pc_ex         = pc;
      bus.i_taken_ex      = t;
      bus.i_target_ex     = tgt;
      bus.i_pred_taken_ex = pt;
      bus.i_pred_pc_ex    = ppc;
   endtask

   task automatic idle_ex();
      set_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t,
                         input logic [31:0] exp_pc);
      bus.i_pc_if = pc;
      #1;
      chk({tag, "_taken"}, {31'b0, bus.o_pred_taken_if}, {31'b0, exp_t});
      chk({tag, "_pc"}, bus.o_pred_pc_if, exp_pc);
   endtask

   task automatic resolve(input string tag, input logic exp_m, input logic [31:0] exp_r);
      #1;
      chk({tag, "_mispred"}, {31'b0, bus.o_mispredict}, {31'b0, exp_m});
      chk({tag, "_redirect"}, bus.o_redirect_pc, exp_r);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      i_reset = 1'b0;
      idle_ex();
      bus.i_pc_if = 32'h100;
      #3;
      lookup("rst", 32'h100, 1'b0, 32'h104);
      chk("rst_mispred", {31'b0, bus.o_mispredict}, 32'h0);
      tick();
      i_reset = 1'b1;

      // Allocate branch at 0x100 taken to 0x80; same-cycle lookup still misses.
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      lookup("same_cyc", 32'h100, 1'b0, 32'h104);
      resolve("alloc", 1'b1, 32'h80);
      tick();
      idle_ex();
      lookup("after_alloc", 32'h100, 1'b1, 32'h80);

      // WT -> WNT -> SNT -> SNT with correct predictions.
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h104);
      resolve("nt1", 1'b0, 32'h104);
      tick();
      idle_ex();
      lookup("wnt", 32'h100, 1'b0, 32'h104);
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      tick();
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      resolve("nt3", 1'b0, 32'h104);
      tick();

      // From SNT one taken leaves it not-taken (WNT); a second gives WT.
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      resolve("t_from_snt", 1'b1, 32'h80);
      tick();
      idle_ex();
      lookup("snt_sat", 32'h100, 1'b0, 32'h104);
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
      idle_ex();
      lookup("wt_again", 32'h100, 1'b1, 32'h80);

      // Aliasing: 0x180 shares index 0 with a different tag.
      lookup("alias_tag", 32'h180, 1'b0, 32'h184);
      set_ex(1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
      resolve("alias_inval", 1'b1, 32'h104);
      tick();
      idle_ex();
      lookup("invalidated", 32'h100, 1'b0, 32'h104);

      // JALR allocation and retarget.
      set_ex(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
      resolve("jalr1", 1'b1, 32'h300);
      tick();
      idle_ex();
      lookup("jalr1_lk", 32'h200, 1'b1, 32'h300);
      set_ex(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h340, 1'b1, 32'h300);
      resolve("jalr2", 1'b1, 32'h340);
      tick();
      idle_ex();
      lookup("jalr2_lk", 32'h200, 1'b1, 32'h340);

      // Entry is ST: one not-taken leaves it predicting taken.
      set_ex(1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h340);
      resolve("st_nt", 1'b1, 32'h204);
      tick();
      idle_ex();
      lookup("st_to_wt", 32'h200, 1'b1, 32'h340);

      set_ex(1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 32'h340, 1'b1, 32'h340);
      resolve("correct", 1'b0, 32'h340);
      tick();

      // Bubble never mispredicts even with a stale prediction.
      set_ex(1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h340);
      resolve("bubble", 1'b0, 32'h204);
      tick();

      // PC wrap at the top of the address space.
      idle_ex();
      lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
      set_ex(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
      resolve("wrap_ex", 1'b0, 32'h0);
      tick();

      // Mid-run reset clears the table immediately.
      idle_ex();
      lookup("pre_rst", 32'h200, 1'b1, 32'h340);
      #2;
      i_reset = 1'b0;
      lookup("in_rst", 32'h200, 1'b0, 32'h204);
      tick();
      i_reset = 1'b1;
      tick();
      lookup("post_rst", 32'h200, 1'b0, 32'h204);

`ifdef BP_PERF_CNT_EN
      chk("cnt_rst_ctrl", bus.o_ctrl_cnt, 32'd0);
      chk("cnt_rst_mis", bus.o_mispred_cnt, 32'd0);
      for (int k = 0; k < 5; k++) begin
         set_ex(1'b1, 1'b1, 1'b0, 32'h400 + 32'(8 * k), 1'b0, 32'h0, 1'b0,
                32'h400 + 32'(8 * k) + ((k == 1 || k == 3) ? 32'd8 : 32'd4));
         tick();
      end
      idle_ex();
      tick();
      chk("cnt_ctrl", bus.o_ctrl_cnt, 32'd5);
      chk("cnt_mis", bus.o_mispred_cnt, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Dynamic branch predictor for the 5-stage RV32I pipeline.
- It is the producer of the mispredict signal that the hazard/forwarding logic consumes to flush IF/ID and ID/EX.
- IF stage: looks up a direct-mapped BTB with 2-bit saturating counters and supplies the predicted next PC.
- EX stage: resolves the actual outcome, raises o_mispredict with a corrected PC, and trains the table.

Parameters:
- BTB_ENTRIES, 32, number of direct-mapped entries; must be a power of 2, minimum 4.
- IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width; derived.

Ports:
- i_clk  input  1  system clock, rising edge
- i_reset  input  1  asynchronous active-low reset
- i_pc_if  input  32  PC of instruction being fetched
- o_pred_taken_if  output  1  prediction: taken
- o_pred_pc_if  output  32  predicted next PC (target if taken, else i_pc_if+4)
- i_valid_ex  input  1  EX holds a real instruction (0 for bubble/flushed slot)
- i_ctrl_ex  input  1  EX instruction is a branch, JAL or JALR
- i_jump_ex  input  1  EX instruction is JAL/JALR (unconditional)
- i_pc_ex  input  32  PC of EX instruction
- i_taken_ex  input  1  actual outcome (1 for jumps)
- i_target_ex  input  32  actual computed target
- i_pred_taken_ex  input  1  prediction carried down the pipeline with the instruction
- i_pred_pc_ex  input  32  predicted next PC carried down the pipeline
- o_mispredict  output  1  redirect request to hazard unit / PC mux
- o_redirect_pc  output  32  correct next PC when o_mispredict=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on i_reset. While reset is low:
  - all valid bits = 0
  - all counters = WNT (2'b01)
  - tags and targets = 0
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational, 0-cycle):
  - hit = valid[idx] && tag match.
  - o_pred_taken_if = hit && counter[1].
  - o_pred_pc_if = o_pred_taken_if ? target[idx] : i_pc_if+4 (32-bit, wraps modulo 2^32).
  - Immediately after reset: o_pred_taken_if=0 and o_pred_pc_if=i_pc_if+4.
- Resolve (combinational, 0-cycle, so the flush happens in the same cycle):
  - actual_npc = i_taken_ex ? i_target_ex : i_pc_ex+4.
  - o_mispredict = i_valid_ex && (i_pred_pc_ex != actual_npc).
  - o_redirect_pc = actual_npc; this value is don't-care when o_mispredict=0, but the bench checks it anyway.
  - o_mispredict=0 whenever i_valid_ex=0, including during reset.
- Train (registered, at rising edge when i_valid_ex=1):
  - ctrl && hit:
    - counter: increment saturating at ST(11) if taken, decrement saturating at SNT(00) if not taken.
    - Jumps force ST.
    - target <= i_target_ex if taken.
  - ctrl && !hit && taken: allocate/replace the entry: valid=1, tag, target, counter = ST for jumps, WT(10) for branches.
  - ctrl && !hit && !taken: no write.
  - !ctrl && i_pred_taken_ex (alias hit on non-control instruction): valid[idx] <= 0.
  - !ctrl && !i_pred_taken_ex: no write.
- Simultaneous IF lookup and EX update of the same index: lookup returns pre-update contents; the new contents are visible from the next cycle.
- Stalls need no port: a load-use stall inserts a bubble into EX (i_valid_ex=0), which suppresses training.
- A replayed IF PC re-reads the table harmlessly.
- Reset asserted mid-operation clears the table immediately; no partial write completes.
- One write port only; no multi-entry update in a cycle.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, adds outputs o_ctrl_cnt[31:0] and o_mispred_cnt[31:0]:
  - o_ctrl_cnt counts cycles with i_valid_ex && i_ctrl_ex.
  - o_mispred_cnt counts cycles with o_mispredict=1.
  - Both are reset to 0 by i_reset, wrap at 2^32, and increment in the same edge as training.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bp_pkg contains:
  - typedef enum logic[1:0] bp_ctr_e {SNT=0, WNT=1, WT=2, ST=3}
  - function bp_ctr_next(bp_ctr_e cur, logic taken) implementing saturation
  - constant BP_PC_STEP=32'd4
- Sub-module bp_sat_counter: one 2-bit saturating counter with async active-low reset to WNT, plus inputs update, taken, force_st. It is instantiated per entry via generate.
- The tag/target/valid arrays stay in the top module.

Test Plan:
- Reset, then i_pc_if=0x100 -> o_pred_taken_if=0, o_pred_pc_if=0x104. Resolve i_valid_ex=0 -> o_mispredict=0.
- Branch at 0x100 resolved taken to 0x80, pred_pc=0x104 -> o_mispredict=1, o_redirect_pc=0x80. Next cycle, lookup 0x100 -> taken, pred_pc=0x80 (counter WT).
- Same branch resolved not-taken twice with correct pred_pc each time -> counter goes WT→WNT→SNT; lookup 0x100 gives pred_pc=0x104. A further not-taken keeps SNT.
- Aliasing (BTB_ENTRIES=32): entry allocated by 0x100; lookup 0x180 (same idx, different tag) -> not taken. Then a non-ctrl at 0x100 with i_pred_taken_ex=1 -> o_mispredict=1, redirect 0x104, entry invalidated.
- JALR at 0x200 with target 0x300, then re-resolved with target 0x340 and pred_pc=0x300 -> o_mispredict=1, redirect 0x340; lookup then returns 0x340 with counter ST.
- Same-cycle: lookup 0x100 while EX allocates 0x100 -> lookup shows not taken that cycle and taken the next. Assert i_reset mid-run -> table cleared, next lookup not taken. With BP_PERF_CNT_EN, check counters after 5 branches with 2 mispredicts = 5 and 2.
